// File: rtl/fp_status_monitor.sv
// Checks an FP multiplier's status flags against its result and operands.
// Violations are sticky, counted with saturation, and the first one is captured.
module fp_status_monitor #(
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned MAN_W   = 23,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [EXP_W+MAN_W:0]   z,
    input  logic [7:0]             status,
    input  logic                   err_clr,
    output logic [5:0]             err_flags,
    output logic [CNT_W-1:0]       err_count,
    output logic                   first_valid,
    output logic [5:0]             first_code,
    output logic [EXP_W+MAN_W:0]   first_a,
    output logic [EXP_W+MAN_W:0]   first_b,
    output logic [EXP_W+MAN_W:0]   first_z
);

    localparam int unsigned W       = 1 + EXP_W + MAN_W;
    localparam int unsigned N_RULE  = 6;
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [EXP_W-1:0] EXP_ZERO  = '0;
    localparam logic [EXP_W-1:0] EXP_ONES1 = EXP_ONES - EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_ZERO1 = EXP_ZERO + EXP_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Operand delay line, aligned with the multiplier latency
    logic [LATENCY-1:0] r_vld;
    logic [W-1:0]       r_da [LATENCY];
    logic [W-1:0]       r_db [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_da[i] <= '0;
                r_db[i] <= '0;
            end
        end else begin
            r_vld[0] <= in_valid;
            r_da[0]  <= a;
            r_db[0]  <= b;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_da[i]  <= r_da[i-1];
                r_db[i]  <= r_db[i-1];
            end
        end
    end

    logic             w_chk_en;
    logic [W-1:0]     w_da;
    logic [W-1:0]     w_db;
    logic [EXP_W-1:0] w_ea;
    logic [EXP_W-1:0] w_eb;
    logic [EXP_W-1:0] w_ez;
    logic             w_st_zero;
    logic             w_st_inf;
    logic             w_st_nan;
    logic             w_st_tiny;
    logic             w_st_huge;
    logic             w_unused;

    assign w_chk_en  = r_vld[LATENCY-1];
    assign w_da      = r_da[LATENCY-1];
    assign w_db      = r_db[LATENCY-1];
    assign w_ea      = w_da[W-2 -: EXP_W];
    assign w_eb      = w_db[W-2 -: EXP_W];
    assign w_ez      = z[W-2 -: EXP_W];
    assign w_st_zero = status[0];
    assign w_st_inf  = status[1];
    assign w_st_nan  = status[2];
    assign w_st_tiny = status[3];
    assign w_st_huge = status[4];
    assign w_unused  = ^status[7:5];

    // Rule evaluation; silent outside checked cycles
    logic [N_RULE-1:0] w_vec;
    logic              w_any;

    always_comb begin
        w_vec = '0;
        if (w_chk_en) begin
            w_vec[0] = w_st_zero && (w_ez != EXP_ZERO);
            w_vec[1] = w_st_inf && (w_ez != EXP_ONES);
            w_vec[2] = w_st_nan &&
                       !(((w_ea == EXP_ZERO) && (w_eb == EXP_ONES)) ||
                         ((w_ea == EXP_ONES) && (w_eb == EXP_ZERO)));
            w_vec[3] = w_st_tiny && (w_ez != EXP_ZERO) && (w_ez != EXP_ZERO1);
            w_vec[4] = w_st_huge && (w_ez != EXP_ONES) && (w_ez != EXP_ONES1);
            w_vec[5] = (2'(w_st_zero) + 2'(w_st_inf) + 2'(w_st_nan)) > 2'd1;
        end
    end

    assign w_any = |w_vec;

    logic [N_RULE-1:0] r_flags;
    logic [CNT_W-1:0]  r_count;
    logic              r_first_valid;
    logic [N_RULE-1:0] r_first_code;
    logic [W-1:0]      r_first_a;
    logic [W-1:0]      r_first_b;
    logic [W-1:0]      r_first_z;

    // Sticky state; a clear still keeps a violation seen in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags       <= '0;
            r_count       <= '0;
            r_first_valid <= 1'b0;
            r_first_code  <= '0;
            r_first_a     <= '0;
            r_first_b     <= '0;
            r_first_z     <= '0;
        end else if (err_clr) begin
            r_flags       <= w_vec;
            r_count       <= CNT_W'(w_any);
            r_first_valid <= w_any;
            r_first_code  <= w_vec;
            r_first_a     <= w_any ? w_da : '0;
            r_first_b     <= w_any ? w_db : '0;
            r_first_z     <= w_any ? z    : '0;
        end else begin
            r_flags <= r_flags | w_vec;
            if (w_any && (r_count != CNT_MAX)) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_any && !r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_code  <= w_vec;
                r_first_a     <= w_da;
                r_first_b     <= w_db;
                r_first_z     <= z;
            end
        end
    end

    assign err_flags   = r_flags;
    assign err_count   = r_count;
    assign first_valid = r_first_valid;
    assign first_code  = r_first_code;
    assign first_a     = r_first_a;
    assign first_b     = r_first_b;
    assign first_z     = r_first_z;

endmodule
